// File: rtl/nand_rr_sched.sv
// nand_rr_sched
//   Round-robin scheduler that shares one registered W-bit bitwise NAND unit
//   (y = ~(a & b)) between N requesters. At most one operand pair is accepted
//   per cycle. It is tagged with its requester index and passes through two
//   register stages: s1 (captured operands) and the output stage (y, y_id,
//   y_vld). Downstream backpressure comes from y_rdy.
//
// Handshake: y, y_id and y_vld form a valid/ready source. A result transfers
//   on an edge where y_vld & y_rdy. While y_vld & ~y_rdy, the output stage
//   holds y and y_id stable. On the request side, req[i] with a[i] and b[i]
//   is held until gnt[i] is seen high. If req[i] is still high during the
//   gnt[i] cycle, it is a fresh request.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [N]    per-requester request
//   a, b   in   [N*W]  operands, requester i at [i*W +: W]
//   gnt    out  [N]    registered one-hot grant, high one cycle per accept
//   y      out  [W]    NAND result
//   y_id   out  [IW]   requester index owning y
//   y_vld  out         y / y_id valid
//   y_rdy  in          downstream ready
module nand_rr_sched #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   y,
  output logic [IW-1:0]  y_id,
  output logic           y_vld,
  input  logic           y_rdy
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;

  logic [W-1:0]  s1_a_q, s1_a_d;
  logic [W-1:0]  s1_b_q, s1_b_d;
  logic [IW-1:0] s1_id_q, s1_id_d;
  logic          s1_vld_q, s1_vld_d;

  logic [W-1:0]  y_q, y_d;
  logic [IW-1:0] y_id_q, y_id_d;
  logic          y_vld_q, y_vld_d;

  logic          stall;
  logic          s1_free;
  logic          grant;
  logic          win_found;
  logic [IW-1:0] win_idx;
  int            cand;

  assign stall   = y_vld_q & ~y_rdy;
  assign s1_free = ~s1_vld_q | ~stall;
  assign grant   = s1_free & (|req);

  // Rotating priority search. The search starts at ptr_q and wraps N-1 -> 0.
  // The first set request found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N) cand = cand - N;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    gnt_d    = '0;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_id_d  = s1_id_q;
    s1_vld_d = s1_vld_q;
    y_d      = y_q;
    y_id_d   = y_id_q;
    y_vld_d  = y_vld_q;

    // The output stage advances whenever it is not stalled. A bubble in s1
    // becomes y_vld=0.
    if (!stall) begin
      y_d     = ~(s1_a_q & s1_b_q);
      y_id_d  = s1_id_q;
      y_vld_d = s1_vld_q;
    end

    if (grant) begin
      gnt_d    = {{(N-1){1'b0}}, 1'b1} << win_idx;
      s1_a_d   = a[win_idx*W +: W];
      s1_b_d   = b[win_idx*W +: W];
      s1_id_d  = win_idx;
      s1_vld_d = 1'b1;
      ptr_d    = (win_idx == IW'(N-1)) ? '0 : win_idx + IW'(1);
    end else if (!stall) begin
      s1_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      gnt_q    <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_id_q  <= '0;
      s1_vld_q <= 1'b0;
      y_q      <= '0;
      y_id_q   <= '0;
      y_vld_q  <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_id_q  <= s1_id_d;
      s1_vld_q <= s1_vld_d;
      y_q      <= y_d;
      y_id_q   <= y_id_d;
      y_vld_q  <= y_vld_d;
    end
  end

  assign gnt   = gnt_q;
  assign y     = y_q;
  assign y_id  = y_id_q;
  assign y_vld = y_vld_q;

endmodule

// File: tb/tb_nand_rr_sched.sv
// tb_nand_rr_sched
//   Directed bench for nand_rr_sched with N=4, W=8. A second instance with
//   N=2 covers alternating grants. Expected grants and results are pushed
//   into queues by the stimulus. A negedge monitor pops and compares them
//   whenever gnt is non-zero or a result transfers.
module tb_nand_rr_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a, b;
  logic [N-1:0]   gnt;
  logic [W-1:0]   y;
  logic [IW-1:0]  y_id;
  logic           y_vld;
  logic           y_rdy;

  logic [1:0]     req2;
  logic [2*W-1:0] a2, b2;
  logic [1:0]     gnt2;
  logic [W-1:0]   y2;
  logic           y2_id;
  logic           y2_vld;
  logic           y2_rdy;

  int n_vec;
  int n_miss;

  logic [N-1:0]    exp_gnt_q[$];
  logic [IW+W-1:0] exp_q[$];

  nand_rr_sched #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .gnt(gnt),
    .y(y), .y_id(y_id), .y_vld(y_vld), .y_rdy(y_rdy)
  );

  nand_rr_sched #(.N(2), .W(W)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .a(a2), .b(b2), .gnt(gnt2),
    .y(y2), .y_id(y2_id), .y_vld(y2_vld), .y_rdy(y2_rdy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] av, input logic [W-1:0] bv);
    a[i*W +: W] = av;
    b[i*W +: W] = bv;
  endtask

  // Queue one expected grant to requester i and its hand-computed result.
  task automatic exp_grant(input int i, input logic [W-1:0] ey);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    exp_gnt_q.push_back(oh);
    exp_q.push_back({IW'(i), ey});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    n_vec++;
    if (got !== need) begin
      n_miss++;
      $display("FAIL %s: got %0h need %0h", name, got, need);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          pend;
  logic [IW-1:0] pend_id;
  logic          prev_stall;
  logic [W-1:0]  prev_y;
  logic [IW-1:0] prev_id;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend       = 1'b0;
      prev_stall = 1'b0;
    end else begin
      // A result must appear one cycle after an unstalled grant cycle.
      if (pend) begin
        check("latency_vld", {31'd0, y_vld}, 32'd1);
        check("latency_id", {30'd0, y_id}, {30'd0, pend_id});
        pend = 1'b0;
      end
      if (prev_stall && y_vld) begin
        check("stall_hold_y", {24'd0, y}, {24'd0, prev_y});
        check("stall_hold_id", {30'd0, y_id}, {30'd0, prev_id});
      end
      if (gnt != '0) begin
        if (exp_gnt_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL gnt_unexpected: got %b need none", gnt);
        end else begin
          check("gnt", {28'd0, gnt}, {28'd0, exp_gnt_q.pop_front()});
        end
        if (!(y_vld && !y_rdy)) begin
          pend = 1'b1;
          pend_id = '0;
          for (int i = 0; i < N; i++) if (gnt[i]) pend_id = IW'(i);
        end
      end
      if (y_vld && y_rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL result_unexpected: got id %0d y %0h need none", y_id, y);
        end else begin
          check("result", {22'd0, y_id, y}, {22'd0, exp_q.pop_front()});
        end
      end
      prev_stall = y_vld && !y_rdy;
      prev_y     = y;
      prev_id    = y_id;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    req = '0;
    a = '0;
    b = '0;
    y_rdy = 1'b1;
    req2 = '0;
    a2 = {8'h0F, 8'hF0};
    b2 = {8'hFF, 8'hFF};
    y2_rdy = 1'b1;
    pend = 1'b0;
    prev_stall = 1'b0;
    prev_y = '0;
    prev_id = '0;

    tick(3);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_y_id", {30'd0, y_id}, 32'd0);
    check("rst_y_vld", {31'd0, y_vld}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // All four requesting: rotation 0,1,2,3,0,1,2,3 from ptr=0.
    set_op(0, 8'hF0, 8'h3C);
    set_op(1, 8'hAA, 8'h0F);
    set_op(2, 8'h55, 8'hFF);
    set_op(3, 8'hC3, 8'h81);
    for (int r = 0; r < 2; r++) begin
      exp_grant(0, 8'hCF);
      exp_grant(1, 8'hF5);
      exp_grant(2, 8'hAA);
      exp_grant(3, 8'h7E);
    end
    req = 4'b1111;
    tick(8);
    req = '0;
    tick(3);

    // Single request: F0 nand 3C = CF.
    exp_grant(0, 8'hCF);
    req = 4'b0001;
    tick(1);
    req = '0;
    tick(3);

    // Grant to 3 leaves ptr=0. Then req=1001 gives 0, 3, 0.
    set_op(3, 8'hFF, 8'hFF);
    set_op(0, 8'h00, 8'hA5);
    exp_grant(3, 8'h00);
    req = 4'b1000;
    tick(1);
    req = '0;
    tick(2);
    exp_grant(0, 8'hFF);
    exp_grant(3, 8'h00);
    exp_grant(0, 8'hFF);
    req = 4'b1001;
    tick(3);
    req = '0;
    tick(3);

    // N=2 instance: alternating grants.
    req2 = 2'b11;
    tick(1);
    check("n2_gnt0", {30'd0, gnt2}, 32'd1);
    tick(1);
    check("n2_gnt1", {30'd0, gnt2}, 32'd2);
    tick(1);
    check("n2_gnt2", {30'd0, gnt2}, 32'd1);
    tick(1);
    check("n2_gnt3", {30'd0, gnt2}, 32'd2);
    req2 = '0;

    // Backpressure: ptr=1 and req=0110. Two grants fill both stages, then gnt=0.
    exp_grant(1, 8'hF5);
    exp_grant(2, 8'hAA);
    exp_grant(1, 8'hF5);
    exp_grant(2, 8'hAA);
    y_rdy = 1'b0;
    req = 4'b0110;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("stall_gnt_zero", {28'd0, gnt}, 32'd0);
    end
    y_rdy = 1'b1;
    tick(2);
    req = '0;
    tick(4);

    // Reset with both stages full. From ptr=3, req=0011 grants 0 then 1.
    exp_gnt_q.push_back(4'b0001);
    exp_gnt_q.push_back(4'b0010);
    y_rdy = 1'b0;
    req = 4'b0011;
    tick(2);
    req = '0;
    tick(2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", {28'd0, gnt}, 32'd0);
    check("async_rst_y", {24'd0, y}, 32'd0);
    check("async_rst_y_id", {30'd0, y_id}, 32'd0);
    check("async_rst_y_vld", {31'd0, y_vld}, 32'd0);
    exp_q.delete();
    req = 4'b1010;
    y_rdy = 1'b1;
    exp_grant(1, 8'hF5);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    req = '0;
    tick(4);

    check("gnt_queue_empty", exp_gnt_q.size(), 32'd0);
    check("result_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
